// File: rtl/queue_pkg.sv
// queue_pkg: constants and types shared by the 8-entry byte queue and its reader.
//   DATA_WIDTH     width of a queue entry
//   LEN_WIDTH      width of the queue occupancy bus (0..QUEUE_DEPTH)
//   QUEUE_DEPTH    number of queue entries
//   reader_state_t reader FSM state encoding
package queue_pkg;

  localparam int unsigned DATA_WIDTH  = 8;
  localparam int unsigned LEN_WIDTH   = 4;
  localparam int unsigned QUEUE_DEPTH = 8;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    POP  = 3'd1,
    WAIT = 3'd2,
    HOLD = 3'd3,
    PACE = 3'd4
  } reader_state_t;

endpackage

// File: rtl/queue_reader.sv
// queue_reader: consumer side of the byte queue. Pops one entry at a time and presents
// it downstream on a valid/ready handshake. All outputs are registered.
//
// Ports:
//   clk_10khz      system clock, rising-edge active
//   reset          asynchronous active-low reset
//   queue_len_in   queue occupancy, sampled only in IDLE
//   queue_data_in  queue head; the popped byte appears here one cycle after the pop
//   dequeue_out    one-cycle pop request to the queue
//   data_out       byte presented downstream, stable while valid_out is high
//   valid_out      data_out holds a byte not yet accepted
//   ready_in       downstream accept, only honoured in HOLD
//   busy_out       high in every state except IDLE
//   count_out      number of bytes accepted downstream, wraps modulo 2^CNT_WIDTH
//
// Build option: define QUEUE_READER_PACE_EN to insert PACE_CYCLES idle clocks (PACE state)
// after each accepted byte. Without it there is no PACE state and no pace counter.
module queue_reader
  import queue_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = queue_pkg::DATA_WIDTH,
  parameter int unsigned LEN_WIDTH   = queue_pkg::LEN_WIDTH,
  parameter int unsigned CNT_WIDTH   = 16,
  parameter int unsigned PACE_CYCLES = 4
) (
  input  logic                  clk_10khz,
  input  logic                  reset,
  input  logic [LEN_WIDTH-1:0]  queue_len_in,
  input  logic [DATA_WIDTH-1:0] queue_data_in,
  output logic                  dequeue_out,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  input  logic                  ready_in,
  output logic                  busy_out,
  output logic [CNT_WIDTH-1:0]  count_out
);

  // Catch nonsensical pacing values at elaboration in every build.
  if (PACE_CYCLES > 32'h0000_FFFF) begin : g_pace_range
    $error("PACE_CYCLES out of range");
  end

  reader_state_t         state_q, state_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  valid_q, valid_d;
  logic                  deq_q, deq_d;
  logic                  busy_q, busy_d;

`ifdef QUEUE_READER_PACE_EN
  localparam int unsigned PaceW = (PACE_CYCLES > 1) ? $clog2(PACE_CYCLES + 1) : 1;
  logic [PaceW-1:0] pace_q, pace_d;
`endif

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    deq_d   = 1'b0;
`ifdef QUEUE_READER_PACE_EN
    pace_d  = pace_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (queue_len_in != '0) begin
          state_d = POP;
          deq_d   = 1'b1;  // registered, so dequeue_out is high exactly while in POP
        end
      end
      POP: state_d = WAIT;
      WAIT: begin
        // The queue updated its head on the pop edge, so the byte is valid now.
        data_d  = queue_data_in;
        valid_d = 1'b1;
        state_d = HOLD;
      end
      HOLD: begin
        if (ready_in) begin
          valid_d = 1'b0;
          cnt_d   = cnt_q + 1'b1;
`ifdef QUEUE_READER_PACE_EN
          if (PACE_CYCLES != 0) begin
            state_d = PACE;
            pace_d  = '0;
          end else begin
            state_d = IDLE;
          end
`else
          state_d = IDLE;
`endif
        end
      end
`ifdef QUEUE_READER_PACE_EN
      PACE: begin
        pace_d = pace_q + 1'b1;
        if (pace_q == PaceW'(PACE_CYCLES - 1)) begin
          state_d = IDLE;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk_10khz or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      data_q  <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      deq_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      deq_q   <= deq_d;
      busy_q  <= busy_d;
    end
  end

`ifdef QUEUE_READER_PACE_EN
  always_ff @(posedge clk_10khz or negedge reset) begin
    if (!reset) begin
      pace_q <= '0;
    end else begin
      pace_q <= pace_d;
    end
  end
`endif

  assign dequeue_out = deq_q;
  assign data_out    = data_q;
  assign valid_out   = valid_q;
  assign busy_out    = busy_q;
  assign count_out   = cnt_q;

endmodule

// File: doc/queue_reader.md
Name: queue_reader

Overview:
- Consumer-side companion to the 8-entry byte queue. Monitors the queue's length output, pops one entry at a time, and presents each byte downstream on a valid/ready handshake.
- Runs in the 10 kHz clock domain, on the same clock as the queue.
- Is the only block allowed to drive the queue's dequeue input.

Parameters:
- DATA_WIDTH, 8, width of queue entries and of the downstream data.
- LEN_WIDTH, 4, width of the queue length bus (values 0..8).
- CNT_WIDTH, 16, width of the delivered-byte counter.
- PACE_CYCLES, 4, minimum idle cycles between pops (used only with the optional feature).

Ports:
- clk_10khz  input  1  system clock, 10 kHz; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- queue_len_in  input  LEN_WIDTH  current queue occupancy (the queue's len_out).
- queue_data_in  input  DATA_WIDTH  queue head data (the queue's data_out).
- dequeue_out  output  1  pop request to the queue; drives the queue's dequeue_in.
- data_out  output  DATA_WIDTH  byte presented downstream.
- valid_out  output  1  data_out holds a byte not yet accepted.
- ready_in  input  1  downstream ready to accept the byte.
- busy_out  output  1  high in every state except IDLE.
- count_out  output  CNT_WIDTH  number of bytes accepted downstream.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE.
  - dequeue_out=0, valid_out=0, data_out=0, busy_out=0, count_out=0, pace counter=0.
  - Reset asserted mid-transfer drops dequeue_out and valid_out immediately; the in-flight byte is discarded and not counted.
- Queue contract: the queue registers data_out on the same rising edge on which it samples dequeue_in=1. The popped byte is therefore valid on queue_data_in one cycle after the pop cycle.
- FSM, all outputs registered:
  - IDLE: if queue_len_in != 0, go to POP. Otherwise stay.
  - POP: dequeue_out=1 for exactly one cycle; next state WAIT.
  - WAIT: dequeue_out=0; latch queue_data_in into data_out; next state HOLD.
  - HOLD: valid_out=1. When ready_in=1 on a rising edge, the transfer completes:
    - count_out increments by 1, wrapping modulo 2^CNT_WIDTH (0xFFFF+1 -> 0x0000);
    - valid_out falls on that same edge;
    - next state is IDLE.
- Timing:
  - Latency from queue_len_in going non-zero (sampled in IDLE) to valid_out=1 is 3 rising edges: IDLE->POP, POP->WAIT, WAIT->HOLD.
  - The minimum cycle per byte is 4 clocks when ready_in is held high.
- Handshake rules:
  - data_out is stable while valid_out=1.
  - valid_out never drops without ready_in.
  - ready_in is ignored outside HOLD.
- Empty queue: never assert dequeue_out while queue_len_in=0. queue_len_in is sampled only in IDLE.
- Full queue (len=8): no special handling; one pop per transfer.
- Simultaneous queue enqueue+dequeue: the length may stay constant. The reader still re-evaluates in IDLE after each transfer.
- Back-pressure: with ready_in held low, the FSM stays in HOLD indefinitely and issues no further pops.

Optional Feature:
- Macro QUEUE_READER_PACE_EN.
- Defined:
  - After each accepted byte, the FSM enters a PACE state and counts PACE_CYCLES clocks before returning to IDLE.
  - busy_out stays 1 during PACE.
  - With PACE_CYCLES=0, PACE is skipped.
- Undefined: no PACE state and no pace counter; HOLD returns directly to IDLE.

Decomposition:
- Shared package queue_pkg holds:
  - the DATA_WIDTH and LEN_WIDTH constants, shared with the queue;
  - QUEUE_DEPTH=8;
  - the enum typedef reader_state_t {IDLE, POP, WAIT, HOLD, PACE}.
- No sub-module: single FSM with an output register and a counter.

Test Plan:
1. Reset with queue_len_in=3, then release reset -> dequeue_out pulses 1 cycle, 1 edge after release. valid_out=1 with data_out=A5 three edges after release.
2. Queue preloaded with 8'hA5,8'h02,8'h03 and ready_in=1 constantly -> bytes A5,02,03 delivered in order, 4 cycles apart. count_out=3. Exactly 3 dequeue pulses. No pop while len=0.
3. ready_in=0 for 10 cycles during HOLD with data_out=8'h77 -> valid_out stays 1, data_out stays 77, no dequeue pulse. Raise ready_in -> count_out increments once.
4. Assert reset in HOLD with count_out=5 -> valid_out=0 and count_out=0 immediately. After release, the reader resumes from IDLE.
5. count_out preset to 0xFFFF by 65535 transfers (or forced) and one more transfer -> count_out=0x0000.
6. With QUEUE_READER_PACE_EN and PACE_CYCLES=4, queue with 2 entries -> second dequeue pulse occurs 4 cycles later than in the non-paced build. busy_out stays 1 throughout.
